player_input_encoder: RTL and testbench
=======================================

// Module: player_input_encoder
// PURPOSE
//  Producer side of the 6-bit player command bus consumed by the game core.
//  Turns raw, bouncy button lines into clean one-hot/multi-hot action words.
//  Emits exactly one command word per game tick, then idles at zero.
//  One instance per player, placed between the button pins and the game core.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable clk cycles before a button state is accepted (>=1)
//  REPEAT_TICKS     8  ticks between auto-repeated moves while LEFT/RIGHT is held (>=2)
//  COOLDOWN_TICKS   3  ticks after an emitted ATTACK during which SPECIAL is refused
//  CNT_W            4  counter width; must hold max(DEBOUNCE_CYCLES,REPEAT_TICKS,COOLDOWN_TICKS)
// PORTS
//  clk            in   1  single system clock
//  rst            in   1  synchronous, active-high reset
//  tick           in   1  one-cycle game-step strobe from the game core
//  btn_raw        in   6  asynchronous raw buttons, 1 = pressed
//  player_input   out  6  action word: [0]LEFT [1]RIGHT [2]ATTACK [3]DEFEND [4]JUMP [5]SPECIAL
//  cmd_valid      out  1  high for exactly the clk after a tick; player_input is meaningful only then
//  conflict       out  1  one-cycle pulse, coincident with cmd_valid, when resolution dropped any action
//  cooldown_busy  out  1  high while the cooldown counter is non-zero
// BEHAVIOUR
//  Reset (rst sampled high at clk): all outputs 0; sync flops, stable states, pending mask,
//   debounce/repeat/cooldown counters cleared. rst overrides tick in the same cycle.
//  Sync: each btn_raw bit passes two flops before use (2-cycle input latency).
//  Debounce per bit: if synced != stable, counter increments; stable flips when the counter
//   reaches DEBOUNCE_CYCLES-1 while still differing; counter clears whenever synced == stable.
//  Press event: stable 0->1. Releases generate no event.
//  Pending mask: press events OR into pending. A press occurring in the same cycle as tick
//   is included in that tick's word, not carried over.
//  On tick, cycle T: raw = pending | press_T | repeat_hit. Registered outputs appear at T+1;
//   pending clears at T+1. All other cycles: player_input = 0, cmd_valid = 0, conflict = 0.
//  Resolution order, applied to raw:
//   1. LEFT and RIGHT both set -> both cleared, conflict.
//   2. ATTACK and DEFEND both set -> ATTACK cleared, conflict.
//   3. SPECIAL set with cooldown != 0 -> SPECIAL cleared, conflict.
//   4. ATTACK surviving -> cooldown loaded with COOLDOWN_TICKS at T+1.
//  Cooldown: decrements by 1 on each tick on which it is non-zero and not being reloaded;
//   saturates at 0. Step 3 uses the value held before the T+1 update.
//  Repeat: while exactly one of LEFT/RIGHT is stable-high and no new press of it is pending,
//   the repeat counter counts ticks. repeat_hit fires on the REPEAT_TICKS-th tick, then the
//   counter reloads. The counter clears on press or release of LEFT/RIGHT, or when both are held.
//  Multiple presses of one button between ticks collapse into one action (mask, not queue).
//  Mid-operation reset discards pending actions; no stale word is emitted after rst deasserts.
//  tick on consecutive cycles is legal; each tick yields its own word, usually 0.
// STRUCTURE
//  Shared package fighting_pkg: ACT_LEFT..ACT_SPECIAL bit indices, ACT_W = 6.
//   The game core consumes the same constants.
//  Sub-module button_debouncer (sync + debounce + press pulse, one bit, DEBOUNCE_CYCLES param),
//   instantiated 6 times via generate. Resolution, repeat and cooldown logic live in the top.
// TESTING
//  1. Press btn_raw[2] clean, DEBOUNCE_CYCLES=4, tick ~8 clk later
//     -> one word 6'b000100 with cmd_valid; next tick -> 6'b000000; cooldown_busy=1.
//  2. Bounce btn_raw[0] 1-0-1 at 1-clk spacing, then hold
//     -> exactly one LEFT word; no press event before 4 stable cycles.
//  3. LEFT and RIGHT pressed before the same tick -> player_input=0, conflict=1 for 1 cycle.
//  4. ATTACK at tick n, SPECIAL before tick n+1 -> SPECIAL dropped with conflict.
//     SPECIAL before tick n+4 -> emitted 6'b100000.
//  5. Hold RIGHT 20 ticks, REPEAT_TICKS=8 -> RIGHT emitted on the first tick after the press,
//     then again 8 and 16 ticks later; nothing between.
//  6. Press JUMP, assert rst 1 clk before tick, then tick -> no JUMP word; all outputs 0
//     the cycle after rst.

Source files
------------

// File: rtl/fighting_pkg.sv
// -----------------------------------------------------------------------------
// fighting_pkg
//   Constants and helpers shared by the player input encoder and the game core.
//   Holds the bit position of every action in the 6-bit command word, the word
//   type, and the conflict-resolution function applied to each tick's actions.
// -----------------------------------------------------------------------------
package fighting_pkg;

  localparam int ACT_W       = 6;
  localparam int ACT_LEFT    = 0;
  localparam int ACT_RIGHT   = 1;
  localparam int ACT_ATTACK  = 2;
  localparam int ACT_DEFEND  = 3;
  localparam int ACT_JUMP    = 4;
  localparam int ACT_SPECIAL = 5;

  typedef logic [ACT_W-1:0] act_t;

  // Result of resolving one tick's raw action set.
  typedef struct packed {
    act_t word;
    logic conflict;
  } resolve_t;

  // Drops mutually exclusive or forbidden actions in a fixed priority order.
  // Each rule looks at the raw set, so dropping LEFT/RIGHT never hides an
  // ATTACK/DEFEND clash and vice versa.
  function automatic resolve_t resolve_actions(input act_t raw,
                                               input logic special_blocked);
    resolve_t r;
    r.word     = raw;
    r.conflict = 1'b0;
    if (raw[ACT_LEFT] && raw[ACT_RIGHT]) begin
      r.word[ACT_LEFT]  = 1'b0;
      r.word[ACT_RIGHT] = 1'b0;
      r.conflict        = 1'b1;
    end
    // Defending wins over attacking.
    if (raw[ACT_ATTACK] && raw[ACT_DEFEND]) begin
      r.word[ACT_ATTACK] = 1'b0;
      r.conflict         = 1'b1;
    end
    if (raw[ACT_SPECIAL] && special_blocked) begin
      r.word[ACT_SPECIAL] = 1'b0;
      r.conflict          = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/player_input_encoder_if.sv
// -----------------------------------------------------------------------------
// player_input_encoder_if
//   Command bus between one player's input encoder (master) and the game core
//   (slave).
//
//   Handshake: the game core pulses tick for one clk to request a step. The
//   encoder answers with cmd_valid high for exactly the following clk;
//   player_input and conflict are meaningful only while cmd_valid is high and
//   are held at zero otherwise. There is no ready/backpressure: the core must
//   accept the word in that single cycle.
//
//   Signals
//     tick          core -> encoder   one-cycle game-step strobe
//     player_input  encoder -> core   action word, one bit per ACT_* index
//     cmd_valid     encoder -> core   qualifies player_input
//     conflict      encoder -> core   resolution dropped an action this word
//     cooldown_busy encoder -> core   SPECIAL currently refused
//     btn_stable    encoder -> core   debounced button levels (observability)
// -----------------------------------------------------------------------------
interface player_input_encoder_if;
  import fighting_pkg::*;

  logic tick;
  act_t player_input;
  logic cmd_valid;
  logic conflict;
  logic cooldown_busy;
  act_t btn_stable;

  modport master (
    input  tick,
    output player_input,
    output cmd_valid,
    output conflict,
    output cooldown_busy,
    output btn_stable
  );

  modport slave (
    output tick,
    input  player_input,
    input  cmd_valid,
    input  conflict,
    input  cooldown_busy,
    input  btn_stable
  );

endinterface

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   One button line: two-flop synchroniser, stability counter, press strobe.
//
//   Ports
//     clk       system clock
//     rst       synchronous active-high reset
//     raw_i     asynchronous raw button level, 1 = pressed
//     stable_o  debounced level
//     press_o   combinational strobe, high in the cycle whose clock edge
//               turns stable_o from 0 to 1 (so the edge that registers the
//               new level can also capture the press)
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter tracks how long the synchronised level has disagreed with the
  // accepted level; any agreement (a bounce back) restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_d & ~stable_q;

endmodule

// File: rtl/player_input_encoder.sv
// -----------------------------------------------------------------------------
// player_input_encoder
//   Producer side of one player's 6-bit command bus. Debounces the buttons,
//   collects press events between game ticks, adds auto-repeat moves for a
//   held LEFT/RIGHT, resolves conflicting actions and emits exactly one
//   registered command word in the clk after each tick.
//
//   Ports
//     clk      system clock
//     rst      synchronous active-high reset (wins over tick)
//     btn_raw  asynchronous raw buttons, bit i = action ACT_* i, 1 = pressed
//     bus      command bus, master side (tick in; word/valid/conflict/
//              cooldown_busy/btn_stable out)
// -----------------------------------------------------------------------------
module player_input_encoder
  import fighting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_TICKS    = 8,
  parameter int COOLDOWN_TICKS  = 3,
  parameter int CNT_W           = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACT_W-1:0]       btn_raw,
  player_input_encoder_if.master bus
);

  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_TICKS);

  act_t stable;
  act_t press;

  // ---------------------------------------------------------------------------
  // Per-button synchronise + debounce
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < ACT_W; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debouncer (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn_raw[g]),
      .stable_o (stable[g]),
      .press_o  (press[g])
    );
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  act_t             pending_q,  pending_d;
  logic [CNT_W-1:0] rep_cnt_q,  rep_cnt_d;
  logic [CNT_W-1:0] cooldown_q, cooldown_d;
  act_t             word_q,     word_d;
  logic             valid_q,    valid_d;
  logic             conflict_q, conflict_d;

  // ---------------------------------------------------------------------------
  // Auto-repeat for a single held direction
  // ---------------------------------------------------------------------------
  logic lr_one;
  logic lr_press;
  logic dir_pending;
  logic repeat_hit;
  act_t dir_mask;

  assign lr_one   = stable[ACT_LEFT] ^ stable[ACT_RIGHT];
  assign lr_press = press[ACT_LEFT] | press[ACT_RIGHT];

  always_comb begin
    dir_mask             = '0;
    dir_mask[ACT_RIGHT]  = stable[ACT_RIGHT];
    dir_mask[ACT_LEFT]   = ~stable[ACT_RIGHT];
  end

  // A fresh press of the held direction already yields a move this tick, so
  // that tick must not also advance the repeat count.
  assign dir_pending = |((pending_q | press) & dir_mask);

  assign repeat_hit = bus.tick & lr_one & ~lr_press & ~dir_pending &
                      (rep_cnt_q == REP_LAST);

  // Releases need no explicit clear: releasing the only held direction makes
  // lr_one false, and releasing one of two held directions starts from a
  // counter that the both-held state already kept at zero.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    if (!lr_one || lr_press) begin
      rep_cnt_d = '0;
    end else if (bus.tick && !dir_pending) begin
      rep_cnt_d = repeat_hit ? '0 : rep_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Action collection, resolution and cooldown
  // ---------------------------------------------------------------------------
  act_t     raw_actions;
  resolve_t res;

  always_comb begin
    raw_actions = pending_q | press;
    if (repeat_hit) begin
      raw_actions = raw_actions | dir_mask;
    end
    res = resolve_actions(raw_actions, cooldown_q != '0);
  end

  always_comb begin
    pending_d  = pending_q | press;
    cooldown_d = cooldown_q;
    word_d     = '0;
    valid_d    = 1'b0;
    conflict_d = 1'b0;
    if (bus.tick) begin
      // Presses landing on the tick cycle are consumed by this word.
      pending_d  = '0;
      word_d     = res.word;
      valid_d    = 1'b1;
      conflict_d = res.conflict;
      if (res.word[ACT_ATTACK]) begin
        cooldown_d = COOL_LOAD;
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      rep_cnt_q  <= '0;
      cooldown_q <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rep_cnt_q  <= rep_cnt_d;
      cooldown_q <= cooldown_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.player_input  = word_q;
  assign bus.cmd_valid     = valid_q;
  assign bus.conflict      = conflict_q;
  assign bus.cooldown_busy = (cooldown_q != '0);
  assign bus.btn_stable    = stable;

endmodule

// File: tb/tb_player_input_encoder.sv
// -----------------------------------------------------------------------------
// tb_player_input_encoder
//   Directed bench for player_input_encoder with DEBOUNCE_CYCLES=4,
//   REPEAT_TICKS=8, COOLDOWN_TICKS=3. Every tick pushes its hand-computed
//   {conflict, word} onto exp_q; a negedge monitor pops one entry per
//   cmd_valid pulse and compares it.
// -----------------------------------------------------------------------------
module tb_player_input_encoder;
  import fighting_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic [ACT_W-1:0] btn_raw;

  always #5 clk = ~clk;

  player_input_encoder_if bus ();

  player_input_encoder #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_TICKS    (8),
    .COOLDOWN_TICKS  (3),
    .CNT_W           (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .bus     (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_ticks  = 0;
  int         n_valid  = 0;
  int         idle_bad = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];
  logic [6:0] mon_exp;
  string      mon_tag;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) begin
      n_valid++;
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check(mon_tag, 32'({bus.conflict, bus.player_input}), 32'(mon_exp));
      end
    end else if (bus.player_input !== '0 || bus.conflict !== 1'b0) begin
      idle_bad++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle tick; the word appears after the next edge and the monitor
  // checks it on the following negedge.
  task automatic do_tick(input string tag, input logic [5:0] w, input logic c);
    exp_q.push_back({c, w});
    tag_q.push_back(tag);
    n_ticks++;
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    btn_raw  = '0;
    bus.tick = 1'b0;
    step(3);
    check("rst_word",     32'(bus.player_input),  32'd0);
    check("rst_valid",    32'(bus.cmd_valid),     32'd0);
    check("rst_conflict", 32'(bus.conflict),      32'd0);
    check("rst_busy",     32'(bus.cooldown_busy), 32'd0);
    rst = 1'b0;
    step(2);

    // 1. Clean ATTACK press; a tick one cycle before debounce completes sees nothing.
    btn_raw[ACT_ATTACK] = 1'b1;
    step(4);
    do_tick("t1_before_debounce", 6'b000000, 1'b0);
    step(2);
    do_tick("t1_attack", 6'b000100, 1'b0);
    check("t1_busy_after_attack", 32'(bus.cooldown_busy), 32'd1);
    do_tick("t1_next", 6'b000000, 1'b0);
    check("t1_busy_cd2", 32'(bus.cooldown_busy), 32'd1);
    btn_raw[ACT_ATTACK] = 1'b0;
    do_tick("t1_drain1", 6'b000000, 1'b0);
    do_tick("t1_drain2", 6'b000000, 1'b0);
    check("t1_busy_clear", 32'(bus.cooldown_busy), 32'd0);
    step(8);

    // 2. LEFT bounces 1-0-1 then holds; the restart delays acceptance.
    btn_raw[ACT_LEFT] = 1'b1;
    step(1);
    btn_raw[ACT_LEFT] = 1'b0;
    step(1);
    btn_raw[ACT_LEFT] = 1'b1;
    step(4);
    do_tick("t2_bounce", 6'b000000, 1'b0);
    step(2);
    do_tick("t2_left", 6'b000001, 1'b0);
    do_tick("t2_once", 6'b000000, 1'b0);
    btn_raw[ACT_LEFT] = 1'b0;
    step(8);

    // 3. LEFT and RIGHT together cancel out.
    btn_raw[ACT_LEFT]  = 1'b1;
    btn_raw[ACT_RIGHT] = 1'b1;
    step(8);
    do_tick("t3_lr_conflict", 6'b000000, 1'b1);
    do_tick("t3_conflict_gone", 6'b000000, 1'b0);
    btn_raw[ACT_LEFT]  = 1'b0;
    btn_raw[ACT_RIGHT] = 1'b0;
    step(8);

    // 4. SPECIAL refused right after ATTACK, accepted once the cooldown expires.
    btn_raw[ACT_ATTACK] = 1'b1;
    step(8);
    do_tick("t4_attack", 6'b000100, 1'b0);
    btn_raw[ACT_ATTACK]  = 1'b0;
    btn_raw[ACT_SPECIAL] = 1'b1;
    step(8);
    do_tick("t4_special_blocked", 6'b000000, 1'b1);
    btn_raw[ACT_SPECIAL] = 1'b0;
    step(8);
    do_tick("t4_tick_n2", 6'b000000, 1'b0);
    do_tick("t4_tick_n3", 6'b000000, 1'b0);
    btn_raw[ACT_SPECIAL] = 1'b1;
    step(8);
    do_tick("t4_special_ok", 6'b100000, 1'b0);
    btn_raw[ACT_SPECIAL] = 1'b0;
    step(8);

    // 4b. ATTACK with DEFEND: DEFEND survives and no cooldown starts.
    btn_raw[ACT_ATTACK] = 1'b1;
    btn_raw[ACT_DEFEND] = 1'b1;
    step(8);
    do_tick("t4_attack_defend", 6'b001000, 1'b1);
    check("t4_no_cooldown", 32'(bus.cooldown_busy), 32'd0);
    btn_raw[ACT_ATTACK] = 1'b0;
    btn_raw[ACT_DEFEND] = 1'b0;
    step(8);

    // 5. Held RIGHT repeats every 8 ticks after the initial press.
    btn_raw[ACT_RIGHT] = 1'b1;
    step(8);
    do_tick("t5_first", 6'b000010, 1'b0);
    for (int i = 1; i < 20; i++) begin
      do_tick($sformatf("t5_hold_%0d", i),
              (i == 8 || i == 16) ? 6'b000010 : 6'b000000, 1'b0);
    end
    btn_raw[ACT_RIGHT] = 1'b0;
    step(8);
    do_tick("t5_released", 6'b000000, 1'b0);

    // 6. Reset one cycle before the tick discards the pending JUMP.
    btn_raw[ACT_JUMP] = 1'b1;
    step(8);
    rst     = 1'b1;
    btn_raw = '0;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_word",     32'(bus.player_input),  32'd0);
    check("t6_rst_valid",    32'(bus.cmd_valid),     32'd0);
    check("t6_rst_conflict", 32'(bus.conflict),      32'd0);
    check("t6_rst_busy",     32'(bus.cooldown_busy), 32'd0);
    do_tick("t6_after_rst", 6'b000000, 1'b0);
    step(4);

    // 7. Reset and tick in the same cycle: reset wins, no word at all.
    btn_raw[ACT_JUMP] = 1'b1;
    step(8);
    rst      = 1'b1;
    bus.tick = 1'b1;
    btn_raw  = '0;
    step(1);
    rst      = 1'b0;
    bus.tick = 1'b0;
    @(negedge clk);
    check("t7_rst_over_tick_valid", 32'(bus.cmd_valid),    32'd0);
    check("t7_rst_over_tick_word",  32'(bus.player_input), 32'd0);
    step(1);
    do_tick("t7_after_rst", 6'b000000, 1'b0);
    step(4);

    // Final bookkeeping.
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("valid_count", 32'(n_valid), 32'(n_ticks));
    check("idle_zero",   32'(idle_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
